// File: rtl/fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA maintenance hooks (sync, TLB flush, MSHR clears, FE flush).
// Optional watchdog on DRAIN/SYNC enabled by defining FENCE_SEQ_TIMEOUT_EN (adds timeout_o).
package fence_sequencer_pkg;
    typedef enum logic [1:0] {
        NoFlush   = 2'd0,
        FlushAll  = 2'd1,
        FlushASID = 2'd2,
        FlushPage = 2'd3
    } tlb_flush_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_SYNC  = 3'd2,
        S_TLBFL = 3'd3,
        S_CLEAR = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;
endpackage

module fence_sequencer
    import fence_sequencer_pkg::*;
#(
    parameter int ASID_LEN    = 16,
    parameter int VPN_LEN     = 27,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_type_i,
    input  logic                req_rs1_zero_i,
    input  logic                req_rs2_zero_i,
    input  logic [ASID_LEN-1:0] req_asid_i,
    input  logic [VPN_LEN-1:0]  req_vpn_i,
    input  logic                abort_i,
    input  logic                lsq_empty_i,
    output logic                synch_l1dc_l2c_o,
    input  logic                l2c_update_done_i,
    output tlb_flush_e          L1TLB_flush_type_o,
    output tlb_flush_e          L2TLB_flush_type_o,
    output logic [ASID_LEN-1:0] flush_asid_o,
    output logic [VPN_LEN-1:0]  flush_page_o,
    output logic                clr_l1tlb_mshr_o,
    output logic                clr_l2tlb_mshr_o,
    output logic                clear_dmshr_dregs_o,
    output logic                flush_fe_o,
`ifdef FENCE_SEQ_TIMEOUT_EN
    output logic                timeout_o,
`endif
    output logic                done_valid_o,
    input  logic                done_ready_i,
    output logic                busy_o
);
    localparam logic [1:0] OP_FENCE  = 2'd0;
    localparam logic [1:0] OP_FENCEI = 2'd1;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [1:0]          r_type;
    logic                r_rs1_zero;
    logic                r_rs2_zero;
    logic [ASID_LEN-1:0] r_asid;
    logic [VPN_LEN-1:0]  r_vpn;
    logic                r_abort_pend;
    logic                w_abort_pend_next;
    logic                w_accept;
    logic                w_to_hit;

    assign w_accept = (r_state == S_IDLE) && req_valid_i;

`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_to_take;

    assign w_to_hit = ((r_state == S_DRAIN) || (r_state == S_SYNC)) &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_state_next != r_state) begin
            r_cnt     <= '0;
            r_timeout <= w_to_take;
        end else if ((r_state == S_DRAIN) || (r_state == S_SYNC)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_type       <= 2'd0;
            r_rs1_zero   <= 1'b0;
            r_rs2_zero   <= 1'b0;
            r_asid       <= '0;
            r_vpn        <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_abort_pend <= w_abort_pend_next;
            if (w_accept) begin
                r_type     <= req_type_i;
                r_rs1_zero <= req_rs1_zero_i;
                r_rs2_zero <= req_rs2_zero_i;
                r_asid     <= req_asid_i;
                r_vpn      <= req_vpn_i;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_abort_pend_next = r_abort_pend;
`ifdef FENCE_SEQ_TIMEOUT_EN
        w_to_take         = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_abort_pend_next = 1'b0;
                if (req_valid_i)
                    w_state_next = (req_type_i == OP_RSVD) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_i)
                    w_state_next = S_IDLE;
                else if (lsq_empty_i)
                    w_state_next = (r_type == OP_FENCE) ? S_DONE : S_SYNC;
                else if (w_to_hit) begin
                    w_state_next = S_DONE;
`ifdef FENCE_SEQ_TIMEOUT_EN
                    w_to_take    = 1'b1;
`endif
                end
            end
            S_SYNC: begin
                // An abort here only takes effect once the writeback reports done.
                w_abort_pend_next = r_abort_pend || abort_i;
                if (l2c_update_done_i) begin
                    if (w_abort_pend_next)
                        w_state_next = S_IDLE;
                    else
                        w_state_next = (r_type == OP_FENCEI) ? S_CLEAR : S_TLBFL;
                end else if (w_to_hit) begin
                    if (w_abort_pend_next)
                        w_state_next = S_IDLE;
                    else begin
                        w_state_next = S_DONE;
`ifdef FENCE_SEQ_TIMEOUT_EN
                        w_to_take    = 1'b1;
`endif
                    end
                end
            end
            S_TLBFL: w_state_next = abort_i ? S_IDLE : S_CLEAR;
            S_CLEAR: w_state_next = abort_i ? S_IDLE : S_DONE;
            S_DONE: begin
                if (abort_i || done_ready_i)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o         = (r_state == S_IDLE);
        busy_o              = (r_state != S_IDLE);
        synch_l1dc_l2c_o    = (r_state == S_SYNC);
        done_valid_o        = (r_state == S_DONE);
        L1TLB_flush_type_o  = NoFlush;
        L2TLB_flush_type_o  = NoFlush;
        flush_asid_o        = '0;
        flush_page_o        = '0;
        clr_l1tlb_mshr_o    = 1'b0;
        clr_l2tlb_mshr_o    = 1'b0;
        clear_dmshr_dregs_o = 1'b0;
        flush_fe_o          = 1'b0;
`ifdef FENCE_SEQ_TIMEOUT_EN
        timeout_o           = r_timeout && (r_state == S_DONE);
`endif
        if (r_state == S_TLBFL) begin
            if (!r_rs1_zero) begin
                L1TLB_flush_type_o = FlushPage;
                flush_page_o       = r_vpn;
                flush_asid_o       = r_asid;
            end else if (!r_rs2_zero) begin
                L1TLB_flush_type_o = FlushASID;
                flush_asid_o       = r_asid;
            end else begin
                L1TLB_flush_type_o = FlushAll;
            end
            L2TLB_flush_type_o = L1TLB_flush_type_o;
        end
        if (r_state == S_CLEAR) begin
            clr_l1tlb_mshr_o    = 1'b1;
            clr_l2tlb_mshr_o    = 1'b1;
            clear_dmshr_dregs_o = (r_type != OP_FENCEI);
            flush_fe_o          = (r_type == OP_FENCEI);
        end
    end
endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer; define FENCE_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_fence_sequencer;
    import fence_sequencer_pkg::*;

`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 1023;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_type_i = 2'd0;
    logic        req_rs1_zero_i = 1'b0;
    logic        req_rs2_zero_i = 1'b0;
    logic [15:0] req_asid_i = '0;
    logic [26:0] req_vpn_i = '0;
    logic        abort_i = 1'b0;
    logic        lsq_empty_i = 1'b0;
    logic        synch_l1dc_l2c_o;
    logic        l2c_update_done_i = 1'b0;
    tlb_flush_e  L1TLB_flush_type_o;
    tlb_flush_e  L2TLB_flush_type_o;
    logic [15:0] flush_asid_o;
    logic [26:0] flush_page_o;
    logic        clr_l1tlb_mshr_o;
    logic        clr_l2tlb_mshr_o;
    logic        clear_dmshr_dregs_o;
    logic        flush_fe_o;
    logic        done_valid_o;
    logic        done_ready_i = 1'b0;
    logic        busy_o;
`ifdef FENCE_SEQ_TIMEOUT_EN
    logic        timeout_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    fence_sequencer #(.ASID_LEN(16), .VPN_LEN(27), .TIMEOUT_CYC(TB_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_type_i(req_type_i),
        .req_rs1_zero_i(req_rs1_zero_i), .req_rs2_zero_i(req_rs2_zero_i),
        .req_asid_i(req_asid_i), .req_vpn_i(req_vpn_i), .abort_i(abort_i),
        .lsq_empty_i(lsq_empty_i), .synch_l1dc_l2c_o(synch_l1dc_l2c_o),
        .l2c_update_done_i(l2c_update_done_i),
        .L1TLB_flush_type_o(L1TLB_flush_type_o), .L2TLB_flush_type_o(L2TLB_flush_type_o),
        .flush_asid_o(flush_asid_o), .flush_page_o(flush_page_o),
        .clr_l1tlb_mshr_o(clr_l1tlb_mshr_o), .clr_l2tlb_mshr_o(clr_l2tlb_mshr_o),
        .clear_dmshr_dregs_o(clear_dmshr_dregs_o), .flush_fe_o(flush_fe_o),
`ifdef FENCE_SEQ_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one request for a single edge, then scrambles the operands so latching is tested.
    task automatic issue(input logic [1:0] t, input logic z1, input logic z2,
                         input logic [15:0] asid, input logic [26:0] vpn);
        req_valid_i = 1'b1; req_type_i = t;
        req_rs1_zero_i = z1; req_rs2_zero_i = z2;
        req_asid_i = asid; req_vpn_i = vpn;
        step();
        req_valid_i = 1'b0; req_type_i = 2'd0;
        req_rs1_zero_i = ~z1; req_rs2_zero_i = ~z2;
        req_asid_i = 16'hFFFF; req_vpn_i = 27'h7FFFFFF;
    endtask

    task automatic run_sfence(input string nm, input logic z1, input logic z2,
                              input logic [15:0] asid, input logic [26:0] vpn,
                              input tlb_flush_e et, input logic [15:0] ea, input logic [26:0] ep);
        lsq_empty_i = 1'b1; l2c_update_done_i = 1'b1; done_ready_i = 1'b1;
        issue(2'd2, z1, z2, asid, vpn);
        chk({nm, "_drain_busy"}, 32'(busy_o), 32'd1);
        step();
        chk({nm, "_sync"}, 32'(synch_l1dc_l2c_o), 32'd1);
        step();
        chk({nm, "_l1type"}, 32'(L1TLB_flush_type_o), 32'(et));
        chk({nm, "_l2type"}, 32'(L2TLB_flush_type_o), 32'(et));
        chk({nm, "_asid"}, 32'(flush_asid_o), 32'(ea));
        chk({nm, "_page"}, 32'(flush_page_o), 32'(ep));
        chk({nm, "_tlbfl_noclr"}, 32'(clr_l1tlb_mshr_o), 32'd0);
        step();
        chk({nm, "_clr"}, {29'd0, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o, clear_dmshr_dregs_o}, 32'h7);
        chk({nm, "_clr_fe"}, 32'(flush_fe_o), 32'd0);
        chk({nm, "_clr_notype"}, 32'(L1TLB_flush_type_o), 32'(NoFlush));
        step();
        chk({nm, "_done"}, 32'(done_valid_o), 32'd1);
        step();
        chk({nm, "_idle"}, 32'(req_ready_o), 32'd1);
        l2c_update_done_i = 1'b0;
        $display("txn %s complete", nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_outs", {24'd0, synch_l1dc_l2c_o, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o,
                         clear_dmshr_dregs_o, flush_fe_o, done_valid_o, 2'b00}, 32'd0);
        chk("rst_types", {28'd0, L1TLB_flush_type_o, L2TLB_flush_type_o}, 32'd0);
        rst_i = 1'b0;
        step();

        // FENCE, all conditions met: done two cycles after accept
        lsq_empty_i = 1'b1; done_ready_i = 1'b1;
        issue(2'd0, 1'b0, 1'b0, 16'h0, 27'h0);
        chk("fence_c1_ready", 32'(req_ready_o), 32'd0);
        chk("fence_c1_done", 32'(done_valid_o), 32'd0);
        step();
        chk("fence_c2_done", 32'(done_valid_o), 32'd1);
        chk("fence_c2_pulses", {28'd0, synch_l1dc_l2c_o, clr_l1tlb_mshr_o, flush_fe_o,
                                clear_dmshr_dregs_o}, 32'd0);
        step();
        chk("fence_ready_back", 32'(req_ready_o), 32'd1);
        chk("fence_done_gone", 32'(done_valid_o), 32'd0);
        $display("txn FENCE complete");

        // FENCE_I with 3 drain cycles and 5 sync cycles
        lsq_empty_i = 1'b0; done_ready_i = 1'b0;
        issue(2'd1, 1'b0, 1'b0, 16'h0, 27'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fencei_drain_nosync", 32'(synch_l1dc_l2c_o), 32'd0);
            if (i == 2) lsq_empty_i = 1'b1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("fencei_sync_held", 32'(synch_l1dc_l2c_o), 32'd1);
            if (i == 4) l2c_update_done_i = 1'b1;
            step();
        end
        l2c_update_done_i = 1'b0;
        chk("fencei_sync_dropped", 32'(synch_l1dc_l2c_o), 32'd0);
        chk("fencei_clear", {28'd0, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o, flush_fe_o,
                             clear_dmshr_dregs_o}, 32'hE);
        step();
        chk("fencei_clear_1cyc", 32'(flush_fe_o), 32'd0);
        chk("fencei_done_hold1", 32'(done_valid_o), 32'd1);
        step();
        chk("fencei_done_hold2", 32'(done_valid_o), 32'd1);
        done_ready_i = 1'b1;
        step();
        chk("fencei_idle", 32'(req_ready_o), 32'd1);
        $display("txn FENCE_I complete");

        run_sfence("sfence_page", 1'b0, 1'b0, 16'h12, 27'h1ABCD, FlushPage, 16'h12, 27'h1ABCD);
        run_sfence("sfence_asid", 1'b1, 1'b0, 16'h7, 27'h55, FlushASID, 16'h7, 27'h0);
        run_sfence("sfence_all", 1'b1, 1'b1, 16'h9, 27'h66, FlushAll, 16'h0, 27'h0);

        // abort pulsed in SYNC: writeback completes, no completion issued
        lsq_empty_i = 1'b1; l2c_update_done_i = 1'b0; done_ready_i = 1'b1;
        issue(2'd1, 1'b0, 1'b0, 16'h0, 27'h0);
        step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_sync_held", 32'(synch_l1dc_l2c_o), 32'd1);
            chk("abort_no_done", 32'(done_valid_o), 32'd0);
            if (i == 3) l2c_update_done_i = 1'b1;
            step();
        end
        l2c_update_done_i = 1'b0;
        chk("abort_idle_ready", 32'(req_ready_o), 32'd1);
        chk("abort_no_clear", {30'd0, clr_l1tlb_mshr_o, done_valid_o}, 32'd0);
        $display("txn FENCE_I aborted in SYNC");

        // reserved type goes straight to DONE and holds until done_ready_i
        done_ready_i = 1'b0;
        issue(2'd3, 1'b0, 1'b0, 16'h0, 27'h0);
        chk("rsvd_done", 32'(done_valid_o), 32'd1);
        chk("rsvd_nosync", 32'(synch_l1dc_l2c_o), 32'd0);
        step();
        chk("rsvd_hold", 32'(done_valid_o), 32'd1);
        done_ready_i = 1'b1;
        step();
        chk("rsvd_idle", 32'(req_ready_o), 32'd1);
        $display("txn RSVD complete");

        // abort in DONE drops the completion
        done_ready_i = 1'b0;
        issue(2'd0, 1'b0, 1'b0, 16'h0, 27'h0);
        step();
        chk("abdone_done", 32'(done_valid_o), 32'd1);
        abort_i = 1'b1;
        step();
        chk("abdone_idle", {30'd0, req_ready_o, done_valid_o}, 32'h2);
        // abort in IDLE is ignored
        step();
        chk("abidle_idle", 32'(busy_o), 32'd0);
        abort_i = 1'b0;
        $display("txn FENCE aborted in DONE");

        // reset while in CLEAR clears outputs immediately
        lsq_empty_i = 1'b1; l2c_update_done_i = 1'b1;
        issue(2'd1, 1'b0, 1'b0, 16'h0, 27'h0);
        step();
        step();
        chk("rstclr_pre", 32'(flush_fe_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstclr_outs", {29'd0, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o, flush_fe_o}, 32'd0);
        chk("rstclr_ready", 32'(req_ready_o), 32'd1);
        step();
        rst_i = 1'b0;
        l2c_update_done_i = 1'b0;
        step();
        chk("rstclr_no_done", 32'(done_valid_o), 32'd0);
        $display("txn FENCE_I reset in CLEAR");

`ifdef FENCE_SEQ_TIMEOUT_EN
        lsq_empty_i = 1'b0; done_ready_i = 1'b0;
        issue(2'd0, 1'b0, 1'b0, 16'h0, 27'h0);
        for (int i = 0; i < 8; i++) begin
            chk("to_drain_wait", 32'(done_valid_o), 32'd0);
            step();
        end
        chk("to_done", 32'(done_valid_o), 32'd1);
        chk("to_flag", 32'(timeout_o), 32'd1);
        chk("to_noclr", 32'(clr_l1tlb_mshr_o), 32'd0);
        done_ready_i = 1'b1;
        step();
        chk("to_flag_clear", 32'(timeout_o), 32'd0);
        $display("txn FENCE timeout in DRAIN");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fence_sequencer.md
Name: fence_sequencer

Overview:
- Sequences memory-ordering and translation-maintenance ops (FENCE, FENCE.I, SFENCE.VMA) issued by the main control unit.
- Drives the existing maintenance hooks in a fixed order: L1D->L2 sync, TLB flush type/ASID/page, MSHR/d-reg clears, front-end flush.
- Sits between the main CU and the TLB/PTW/d-cache update block.
- One op is in flight at a time; the CU stalls on busy_o.

Parameters:
- ASID_LEN, 16, width of flush ASID.
- VPN_LEN, 27, width of flush VPN (Sv39).
- TIMEOUT_CYC, 1023, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  op request.
- req_ready_o  out  1  sequencer can accept an op.
- req_type_i  in  2  op type: 0 FENCE, 1 FENCE_I, 2 SFENCE_VMA, 3 reserved.
- req_rs1_zero_i  in  1  SFENCE rs1==x0.
- req_rs2_zero_i  in  1  SFENCE rs2==x0.
- req_asid_i  in  ASID_LEN  SFENCE ASID operand.
- req_vpn_i  in  VPN_LEN  SFENCE VPN operand.
- abort_i  in  1  cancel current op.
- lsq_empty_i  in  1  load/store queue drained.
- synch_l1dc_l2c_o  out  1  request L1D->L2 writeback sync.
- l2c_update_done_i  in  1  sync complete.
- L1TLB_flush_type_o  out  tlb_flush_e  L1 TLB flush command.
- L2TLB_flush_type_o  out  tlb_flush_e  L2 TLB flush command.
- flush_asid_o  out  ASID_LEN  ASID for flush.
- flush_page_o  out  VPN_LEN  VPN for flush.
- clr_l1tlb_mshr_o  out  1  clear L1 TLB MSHR.
- clr_l2tlb_mshr_o  out  1  clear L2 TLB MSHR.
- clear_dmshr_dregs_o  out  1  clear D-cache MSHR/d-regs.
- flush_fe_o  out  1  flush fetch/front end.
- done_valid_o  out  1  op complete.
- done_ready_i  in  1  CU accepts completion.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE; req_ready_o=1; all other outputs 0; flush types NoFlush; latched operands 0.
- Handshake: accept when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. On accept, latch type, ASID, VPN and zero flags; the next cycle is DRAIN.
- Reserved type 3: accepted, goes straight to DONE with no side effects.
- State DRAIN: wait for lsq_empty_i==1. The exit target depends on type:
  - FENCE -> DONE.
  - FENCE_I, SFENCE_VMA -> SYNC.
- State SYNC:
  - synch_l1dc_l2c_o held at 1 every cycle in SYNC.
  - Exit when l2c_update_done_i==1 (sampled in SYNC): FENCE_I -> CLEAR, SFENCE_VMA -> TLBFL.
  - If l2c_update_done_i is already 1 on SYNC entry, exit after exactly 1 cycle.
- State TLBFL: exactly 1 cycle. L1TLB_flush_type_o and L2TLB_flush_type_o both driven with the same value:
  - rs1_zero && rs2_zero: FlushAll.
  - rs1_zero && !rs2_zero: FlushASID, flush_asid_o = latched ASID.
  - !rs1_zero: FlushPage, flush_page_o = latched VPN, flush_asid_o = latched ASID.
  - Next state CLEAR.
- State CLEAR: exactly 1 cycle. clr_l1tlb_mshr_o=1 and clr_l2tlb_mshr_o=1, plus:
  - SFENCE_VMA: also clear_dmshr_dregs_o=1.
  - FENCE_I: also flush_fe_o=1.
  - Next state DONE.
- State DONE: done_valid_o=1 until done_ready_i, then IDLE. req_ready_o returns to 1 the cycle after the done handshake.
- Minimum latencies, from accept to done_valid_o with all conditions already met:
  - FENCE: 2 cycles.
  - FENCE_I: 4 cycles.
  - SFENCE_VMA: 5 cycles.
- Outputs are driven from registered state (Moore). Flush types are NoFlush outside TLBFL. Pulse outputs are 0 outside their state.
- abort_i (priority over every other transition):
  - In DRAIN, TLBFL, CLEAR or DONE -> IDLE next cycle, with no done_valid_o.
  - In SYNC: keep synch_l1dc_l2c_o asserted, set a pending-abort flag, and go to IDLE on l2c_update_done_i. An in-flight writeback is never abandoned.
  - In IDLE: ignored.
- rst_i mid-op: immediate return to reset values; no completion is issued.

Optional Feature:
- Macro FENCE_SEQ_TIMEOUT_EN.
- When defined:
  - A 10-bit+ counter (width clog2(TIMEOUT_CYC+1)) clears on every state change and increments while in DRAIN or SYNC.
  - On reaching TIMEOUT_CYC: go to DONE with extra output timeout_o=1, which stays 1 while in DONE. TLBFL and CLEAR are skipped.
  - In SYNC, a timeout also drops synch_l1dc_l2c_o.
- When undefined: no counter, no timeout_o port; DRAIN and SYNC wait indefinitely.

Test Plan:
- FENCE with lsq_empty_i=1, done_ready_i=1 -> done_valid_o 2 cycles after accept; no sync/flush/clear pulses.
- FENCE_I, lsq_empty_i low 3 cycles, l2c_update_done_i 5 cycles after SYNC entry -> synch_l1dc_l2c_o high exactly 5 cycles; then a 1-cycle clr_l1tlb/clr_l2tlb/flush_fe pulse; then done.
- SFENCE_VMA with rs1 nonzero, VPN 0x1ABCD, ASID 0x12 -> one TLBFL cycle with both types FlushPage, flush_page_o=0x1ABCD, flush_asid_o=0x12; next cycle clr_* and clear_dmshr_dregs_o=1.
- SFENCE_VMA with rs1=x0, rs2 nonzero, ASID 0x7 -> FlushASID, flush_asid_o=0x7. Separately, both zero -> FlushAll.
- abort_i pulsed in SYNC, done 4 cycles later -> synch held until done; IDLE the next cycle; done_valid_o never asserted; req_ready_o=1 again.
- FENCE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, lsq_empty_i held 0 -> DONE after 8 DRAIN cycles with timeout_o=1 and no clears. Also: rst_i asserted in CLEAR -> all outputs 0 in the same cycle.
